// File: rtl/wbx_pkg.sv
// Shared widths and index helpers for the wbx single-master pipelined interconnect.
package wbx_pkg;

  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  // Slave-index field width; at least one bit so a single-slave build still decodes.
  function automatic int idx_w(input int periph_num);
    return (periph_num > 1) ? $clog2(periph_num) : 1;
  endfunction

  // The owner register must also hold the unmapped pseudo-index, hence periph_num + 1 codes.
  function automatic int cur_w(input int periph_num);
    return $clog2(periph_num + 1);
  endfunction

  function automatic int cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

  // Owner code recorded for accepted requests that decode to no slave.
  function automatic int unmapped_idx(input int periph_num);
    return periph_num;
  endfunction

endpackage

// File: rtl/wbx_watchdog.sv
// Hung-slave watchdog: counts silent cycles while requests are outstanding and
// raises a one-cycle timeout when the limit is reached.
module wbx_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  input  logic resp,
  output logic timeout
);

  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDW-1:0] wd_cnt;

  // The cycle that completes the silent stretch fires directly, so the pulse
  // lands TIMEOUT_CYCLES cycles after the request was accepted.
  assign timeout = busy & ~resp & (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (!busy || resp || timeout) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wbx_1master_n.sv
// Single-master Wishbone B4 pipelined interconnect to PERIPH_NUM slaves.
// Define WBX_TIMEOUT_EN to add the hung-slave watchdog (wbx_watchdog).
module wbx_1master_n
  import wbx_pkg::*;
#(
  parameter int PERIPH_NUM     = 4,
  parameter int MADR_W         = 16,
  parameter int SADR_W         = 4,
  parameter int SEL_LSB        = 12,
  parameter int MAX_OUT        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_ni,
  input  logic                           wbm_cyc_o,
  input  logic                           wbm_stb_o,
  input  logic                           wbm_we_o,
  input  logic [MADR_W-1:0]              wbm_adr_o,
  input  logic [WB_SEL_W-1:0]            wbm_sel_o,
  input  logic [WB_DAT_W-1:0]            wbm_dat_o,
  output logic [WB_DAT_W-1:0]            wbm_dat_i,
  output logic                           wbm_stall_i,
  output logic                           wbm_ack_i,
  output logic                           wbm_err_i,
  output logic [PERIPH_NUM-1:0]          wbs_cyc_i,
  output logic                           wbs_stb_i,
  output logic                           wbs_we_i,
  output logic [SADR_W-1:0]              wbs_adr_i,
  output logic [WB_SEL_W-1:0]            wbs_sel_i,
  output logic [WB_DAT_W-1:0]            wbs_dat_i,
  input  logic [WB_DAT_W*PERIPH_NUM-1:0] wbs_dat_o,
  input  logic [PERIPH_NUM-1:0]          wbs_stall_o,
  input  logic [PERIPH_NUM-1:0]          wbs_ack_o
);

  localparam int IDXW = idx_w(PERIPH_NUM);
  localparam int CURW = cur_w(PERIPH_NUM);
  localparam int CNTW = cnt_w(MAX_OUT);
  localparam logic [CURW-1:0] UNMAPPED = CURW'(unmapped_idx(PERIPH_NUM));

  if (PERIPH_NUM < 1 || PERIPH_NUM > 16 || MAX_OUT < 1 || MAX_OUT > 15 ||
      TIMEOUT_CYCLES < 1 || SEL_LSB + IDXW > MADR_W || SADR_W > MADR_W) begin : g_bad_param
    $error("wbx_1master_n: parameter out of range");
  end

  logic [CNTW-1:0] cnt;
  logic [CURW-1:0] cur;
  logic            err_q;

  logic [IDXW-1:0] tgt;
  logic [CURW-1:0] eff_tgt;
  logic            mapped, busy, full, switch_wait, slave_stall, ack_raw;
  logic            acc, resp, hold;
  logic            unused_adr;

  assign tgt     = wbm_adr_o[SEL_LSB +: IDXW];
  assign mapped  = CURW'(tgt) < UNMAPPED;
  assign eff_tgt = mapped ? CURW'(tgt) : UNMAPPED;
  assign busy    = (cnt != '0);
  assign full    = (cnt == CNTW'(MAX_OUT));
  // Unmapped requests compare by pseudo-index, so a run of them pipelines
  // (one err per cycle) instead of stalling on each other.
  assign switch_wait = busy & (eff_tgt != cur);
  assign unused_adr  = ^wbm_adr_o;

  assign wbs_stb_i = wbm_stb_o & mapped & ~switch_wait & ~full & ~hold;
  assign wbs_we_i  = wbm_we_o;
  assign wbs_adr_i = wbm_adr_o[SADR_W-1:0];
  assign wbs_sel_i = wbm_sel_o;
  assign wbs_dat_i = wbm_dat_o;

  // NOTE: every signal written in an always_comb gets a default first; a path
  // that skips an assignment would otherwise infer a latch.
  always_comb begin
    slave_stall = 1'b0;
    ack_raw     = 1'b0;
    wbm_dat_i   = '0;
    wbs_cyc_i   = '0;
    for (int k = 0; k < PERIPH_NUM; k++) begin
      if (tgt == IDXW'(k)) slave_stall = wbs_stall_o[k];
      if (cur == CURW'(k)) begin
        ack_raw   = wbs_ack_o[k];
        wbm_dat_i = wbs_dat_o[k*WB_DAT_W +: WB_DAT_W];
      end
      wbs_cyc_i[k] = wbm_cyc_o & ~hold &
                     ((busy & (cur == CURW'(k))) | (wbm_stb_o & mapped & (tgt == IDXW'(k))));
    end
  end

  assign wbm_stall_i = (mapped & slave_stall) | full | switch_wait | hold;
  assign acc         = wbm_cyc_o & wbm_stb_o & ~wbm_stall_i;
  assign wbm_ack_i   = busy & ack_raw;
  assign wbm_err_i   = err_q | hold;
  assign resp        = wbm_ack_i | err_q;

`ifdef WBX_TIMEOUT_EN
  // A timeout holds off the bus for its error cycle, then the owner is released.
  wbx_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_ni),
    .busy   (busy & wbm_cyc_o),
    .resp   (ack_raw | err_q),
    .timeout(hold)
  );
`else
  assign hold = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt   <= '0;
      cur   <= '0;
      err_q <= 1'b0;
    end else if (!wbm_cyc_o || hold) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt   <= cnt + CNTW'(acc) - CNTW'(resp);
      err_q <= acc & ~mapped;
      if (acc) cur <= eff_tgt;
    end
  end

endmodule

// File: tb/tb_wbx_1master_n.sv
// Self-checking bench for wbx_1master_n: per-cycle vector table plus a response
// scoreboard; adds the watchdog sequence when WBX_TIMEOUT_EN is defined.
module tb_wbx_1master_n;

  // Five slaves so the 3-bit index field has unmapped codes (5..7); with four
  // slaves every 2-bit index would decode to a slave.
  localparam int PN     = 5;
  localparam int TO_CYC = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              m_cyc, m_stb, m_we;
  logic [15:0]       m_adr;
  logic [3:0]        m_sel;
  logic [31:0]       m_dat;
  logic [31:0]       m_rdat;
  logic              m_stall, m_ack, m_err;
  logic [PN-1:0]     s_cyc;
  logic              s_stb, s_we;
  logic [3:0]        s_adr, s_sel;
  logic [31:0]       s_wdat;
  logic [32*PN-1:0]  s_rdat;
  logic [PN-1:0]     s_stall, s_ack;
  logic              dat_en;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          cyc, stb, we;
    logic [15:0]   adr;
    logic [PN-1:0] sack, sstall;
    logic          hang;
    logic          stall;
    logic [PN-1:0] scyc;
    logic          sstb, ack, err;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] dat;
  } rsp_t;

  vec_t tbl[$];
  rsp_t sb_q[$];

  always #5 clk = ~clk;

  wbx_1master_n #(
    .PERIPH_NUM(PN), .MADR_W(16), .SADR_W(4), .SEL_LSB(12), .MAX_OUT(4), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbm_cyc_o(m_cyc), .wbm_stb_o(m_stb), .wbm_we_o(m_we), .wbm_adr_o(m_adr),
    .wbm_sel_o(m_sel), .wbm_dat_o(m_dat), .wbm_dat_i(m_rdat),
    .wbm_stall_i(m_stall), .wbm_ack_i(m_ack), .wbm_err_i(m_err),
    .wbs_cyc_i(s_cyc), .wbs_stb_i(s_stb), .wbs_we_i(s_we), .wbs_adr_i(s_adr),
    .wbs_sel_i(s_sel), .wbs_dat_i(s_wdat), .wbs_dat_o(s_rdat),
    .wbs_stall_o(s_stall), .wbs_ack_o(s_ack)
  );

  function automatic logic [31:0] sdat(input int k);
    case (k)
      0:       return 32'h1111_0000;
      1:       return 32'h2222_1111;
      2:       return 32'hDEAD_BEEF;
      3:       return 32'h4444_3333;
      default: return 32'h5555_4444;
    endcase
  endfunction

  always_comb begin
    s_rdat = '0;
    if (dat_en) for (int k = 0; k < PN; k++) s_rdat[k*32 +: 32] = sdat(k);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic cyc, stb, we, input logic [15:0] adr,
                               input logic [PN-1:0] sack, sstall, input logic hang,
                               input logic stall, input logic [PN-1:0] scyc,
                               input logic sstb, ack, err);
    vec_t v;
    v.cyc = cyc; v.stb = stb; v.we = we; v.adr = adr; v.sack = sack; v.sstall = sstall;
    v.hang = hang; v.stall = stall; v.scyc = scyc; v.sstb = sstb; v.ack = ack; v.err = err;
    return v;
  endfunction

  // Entered at posedge+1; drives one cycle, checks mid-cycle, returns at the next posedge+1.
  task automatic run_vec(input vec_t v, input string tag);
    rsp_t        r;
    logic [2:0]  idx;
    m_cyc = v.cyc; m_stb = v.stb; m_we = v.we; m_adr = v.adr;
    m_sel = 4'hF;  m_dat = {16'h5A00, v.adr};
    s_ack = v.sack; s_stall = v.sstall;
    #2;
    check({tag, "/stall"}, m_stall, v.stall);
    check({tag, "/scyc"},  s_cyc,   v.scyc);
    check({tag, "/sstb"},  s_stb,   v.sstb);
    check({tag, "/ack"},   m_ack,   v.ack);
    check({tag, "/err"},   m_err,   v.err);
    check({tag, "/sadr"},  s_adr,   v.adr[3:0]);
    if (!v.cyc) sb_q.delete();
    if (m_ack || m_err) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s/sb_unexpected: got ack=%0b err=%0b, expected no response", tag, m_ack, m_err);
      end else begin
        r = sb_q.pop_front();
        check({tag, "/sb_err"}, m_err, r.err);
        if (!r.err) check({tag, "/sb_dat"}, m_rdat, r.dat);
      end
    end
    idx = v.adr[14:12];
    if (v.cyc && v.stb && !v.stall) begin
      r.err = (int'(idx) >= PN) | v.hang;
      r.dat = (int'(idx) < PN) ? sdat(int'(idx)) : 32'h0;
      sb_q.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "time limit reached");
  end

  initial begin
    // A: read slave 2 at 0x2003, ack next cycle.
    tbl.push_back(mkv(1,1,0,16'h2003, 5'b00000,5'b00000,0, 0,5'b00100,1,0,0));
    tbl.push_back(mkv(1,0,0,16'h2003, 5'b00100,5'b00000,0, 0,5'b00100,0,1,0));
    tbl.push_back(mkv(0,0,0,16'h2003, 5'b00000,5'b00000,0, 0,5'b00000,0,0,0));
    // B: four pipelined writes to slave 1, fifth stalls while MAX_OUT are in flight.
    tbl.push_back(mkv(1,1,1,16'h1000, 5'b00000,5'b00000,0, 0,5'b00010,1,0,0));
    tbl.push_back(mkv(1,1,1,16'h1001, 5'b00000,5'b00000,0, 0,5'b00010,1,0,0));
    tbl.push_back(mkv(1,1,1,16'h1002, 5'b00000,5'b00000,0, 0,5'b00010,1,0,0));
    tbl.push_back(mkv(1,1,1,16'h1003, 5'b00000,5'b00000,0, 0,5'b00010,1,0,0));
    tbl.push_back(mkv(1,1,1,16'h1004, 5'b00000,5'b00000,0, 1,5'b00010,0,0,0));
    tbl.push_back(mkv(1,1,1,16'h1004, 5'b00010,5'b00000,0, 1,5'b00010,0,1,0));
    tbl.push_back(mkv(1,1,1,16'h1004, 5'b00010,5'b00000,0, 0,5'b00010,1,1,0));
    tbl.push_back(mkv(1,0,1,16'h1004, 5'b00010,5'b00000,0, 0,5'b00010,0,1,0));
    tbl.push_back(mkv(1,0,1,16'h1004, 5'b00010,5'b00000,0, 0,5'b00010,0,1,0));
    tbl.push_back(mkv(1,0,1,16'h1004, 5'b00010,5'b00000,0, 0,5'b00010,0,1,0));
    // C: slave 0 then slave 3; switch waits for the drain, then a slave stall.
    tbl.push_back(mkv(1,1,1,16'h0000, 5'b00000,5'b00000,0, 0,5'b00001,1,0,0));
    tbl.push_back(mkv(1,1,1,16'h3000, 5'b00000,5'b00000,0, 1,5'b01001,0,0,0));
    tbl.push_back(mkv(1,1,1,16'h3000, 5'b00001,5'b00000,0, 1,5'b01001,0,1,0));
    tbl.push_back(mkv(1,1,1,16'h3000, 5'b00000,5'b01000,0, 1,5'b01000,1,0,0));
    tbl.push_back(mkv(1,1,1,16'h3000, 5'b00000,5'b00000,0, 0,5'b01000,1,0,0));
    tbl.push_back(mkv(1,0,1,16'h3000, 5'b01000,5'b00000,0, 0,5'b01000,0,1,0));
    // D: back-to-back unmapped (tgt 5, 7), then a mapped request waits for the err.
    tbl.push_back(mkv(1,1,0,16'h5000, 5'b00000,5'b00000,0, 0,5'b00000,0,0,0));
    tbl.push_back(mkv(1,1,0,16'h7000, 5'b00000,5'b00000,0, 0,5'b00000,0,0,1));
    tbl.push_back(mkv(1,1,0,16'h0000, 5'b00000,5'b00000,0, 1,5'b00001,0,0,1));
    tbl.push_back(mkv(1,1,0,16'h0000, 5'b00000,5'b00000,0, 0,5'b00001,1,0,0));
    tbl.push_back(mkv(1,0,0,16'h0000, 5'b00001,5'b00000,0, 0,5'b00001,0,1,0));
    // E: two outstanding, master drops cyc, late and stray acks are ignored.
    tbl.push_back(mkv(1,1,0,16'h1000, 5'b00000,5'b00000,0, 0,5'b00010,1,0,0));
    tbl.push_back(mkv(1,1,0,16'h1001, 5'b00000,5'b00000,0, 0,5'b00010,1,0,0));
    tbl.push_back(mkv(0,0,0,16'h1000, 5'b00000,5'b00000,0, 0,5'b00000,0,0,0));
    tbl.push_back(mkv(0,0,0,16'h1000, 5'b00010,5'b00000,0, 0,5'b00000,0,0,0));
    tbl.push_back(mkv(1,0,0,16'h1000, 5'b00010,5'b00000,0, 0,5'b00000,0,0,0));

    // Reset state; shared fields pass through even while reset is held.
    rst_n = 1'b0; dat_en = 1'b0;
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b1; m_adr = 16'h2003;
    m_sel = 4'hA; m_dat = 32'hCAFE_F00D; s_ack = '0; s_stall = '0;
    #12;
    check("rst/stall", m_stall, 1'b0);
    check("rst/ack",   m_ack,   1'b0);
    check("rst/err",   m_err,   1'b0);
    check("rst/scyc",  s_cyc,   '0);
    check("rst/sstb",  s_stb,   1'b0);
    check("rst/rdat",  m_rdat,  32'h0);
    check("rst/sadr",  s_adr,   4'h3);
    check("rst/swe",   s_we,    1'b1);
    check("rst/ssel",  s_sel,   4'hA);
    check("rst/sdat",  s_wdat,  32'hCAFE_F00D);
    #1 rst_n = 1'b1;
    dat_en = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("v%0d", i));
    check("tbl/sb_drained", sb_q.size(), 0);

    // Reset asserted mid-burst with an ack pending.
    run_vec(mkv(1,1,1,16'h2000, 5'b00000,5'b00000,0, 0,5'b00100,1,0,0), "r0");
    run_vec(mkv(1,1,1,16'h2001, 5'b00000,5'b00000,0, 0,5'b00100,1,0,0), "r1");
    m_stb = 1'b0; s_ack = 5'b00100;
    #2;
    check("r2/pre_ack",  m_ack,  1'b1);
    check("r2/pre_rdat", m_rdat, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    #1;
    check("r2/rst_ack",   m_ack,   1'b0);
    check("r2/rst_err",   m_err,   1'b0);
    check("r2/rst_scyc",  s_cyc,   '0);
    check("r2/rst_stall", m_stall, 1'b0);
    sb_q.delete();
    m_cyc = 1'b0; s_ack = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_vec(mkv(1,1,0,16'h0000, 5'b00000,5'b00000,0, 0,5'b00001,1,0,0), "r3");
    run_vec(mkv(1,0,0,16'h0000, 5'b00001,5'b00000,0, 0,5'b00001,0,1,0), "r4");

`ifdef WBX_TIMEOUT_EN
    // Slave 2 never acks: err on cycle TO_CYC after accept, then slave 0 proceeds.
    run_vec(mkv(1,1,0,16'h2000, 5'b00000,5'b00000,1, 0,5'b00100,1,0,0), "t0");
    for (int c = 1; c < TO_CYC; c++)
      run_vec(mkv(1,0,0,16'h2000, 5'b00000,5'b00000,0, 0,5'b00100,0,0,0), $sformatf("t%0d", c));
    run_vec(mkv(1,0,0,16'h2000, 5'b00000,5'b00000,0, 1,5'b00000,0,0,1), "t_err");
    run_vec(mkv(1,1,0,16'h0000, 5'b00000,5'b00000,0, 0,5'b00001,1,0,0), "t_next");
    run_vec(mkv(1,0,0,16'h0000, 5'b00001,5'b00000,0, 0,5'b00001,0,1,0), "t_ack");
`endif

    check("end/sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
